// File: rtl/encoder_16.sv
// -----------------------------------------------------------------------------
// encoder_16 -- registered 16-to-4 request encoder
//
// Collects up to 16 request lines into a pending register and hands them out
// one index at a time over a valid/ready handshake. Each index is cleared from
// the pending register when its handshake completes. This is the encode-side
// counterpart to the 4-to-16 select decoders: many request/strobe sources are
// funnelled onto a single 4-bit select bus.
//
// Handshake: out_valid/out_index form the producer side and out_ready is the
// consumer side. A transfer happens on a rising edge where out_valid and
// out_ready are both 1. Once out_valid rises, out_index holds stable until
// that transfer. out_ready has no effect while out_valid is 0.
//
// Parameters:
//   STICKY      1: a request bit stays pending until its index is served.
//               0: the pending register reloads from req every cycle
//                  (level mode), minus the index acknowledged that cycle.
//
// Compile-time option:
//   ENCODER_16_ROUND_ROBIN_EN  When defined, a 4-bit last-grant pointer is
//               added and selection searches upward from pointer+1 with
//               wrap-around, so no index can be starved. When undefined,
//               selection is fixed priority with bit 0 the highest.
//
// Ports:
//   clock       in   1   system clock, all state changes on the rising edge
//   reset       in   1   synchronous active-high reset
//   enable      in   1   gates request capture; draining continues when low
//   req         in  16   request lines, bit i requests index i
//   out_ready   in   1   consumer accepts out_index this cycle
//   out_valid   out  1   out_index holds a pending request
//   out_index   out  4   encoded index of the presented request
//   pend_count  out  5   registered popcount of the pending register
//   pending     out 16   current pending register
//   state_dbg   out  1   FSM state for debug (0 = IDLE, 1 = PRESENT)
// -----------------------------------------------------------------------------
module encoder_16 #(
   parameter bit STICKY = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] req,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [3:0]  out_index,
   output logic [4:0]  pend_count,
   output logic [15:0] pending,
   output logic        state_dbg
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_e;

   // ---------------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------------

   // Number of set bits in a 16-bit vector (0..16).
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'b0000, v[i]};
      end
      return n;
   endfunction

`ifdef ENCODER_16_ROUND_ROBIN_EN
   // First set bit found searching upward from p+1, wrapping 15 -> 0.
   // p itself is examined last, so the previous grant has lowest priority.
   function automatic logic [3:0] sel_rr(input logic [15:0] v,
                                         input logic [3:0]  p);
      logic [3:0] r;
      logic [3:0] c;
      logic       found;
      r     = '0;
      found = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         c = p + 4'(k);
         if (!found && v[c]) begin
            r     = c;
            found = 1'b1;
         end
      end
      return r;
   endfunction
`else
   // Lowest set bit wins. Scanning downward lets the last hit be the lowest.
   function automatic logic [3:0] sel_fixed(input logic [15:0] v);
      logic [3:0] r;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            r = 4'(i);
         end
      end
      return r;
   endfunction
`endif

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e      state_q,      state_d;
   logic [15:0] pending_q,    pending_d;
   logic [4:0]  pend_count_q, pend_count_d;
   logic        out_valid_q,  out_valid_d;
   logic [3:0]  out_index_q,  out_index_d;
`ifdef ENCODER_16_ROUND_ROBIN_EN
   logic [3:0]  ptr_q,        ptr_d;
   logic [3:0]  sel_base;
`endif

   logic        hs;
   logic [15:0] ack_mask;
   logic [15:0] req_in;
   logic [15:0] remaining;
   logic [3:0]  sel_idle;
   logic [3:0]  sel_rem;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      hs       = out_valid_q & out_ready;
      ack_mask = hs ? (16'h0001 << out_index_q) : 16'h0000;
      req_in   = enable ? req : 16'h0000;

      // Requests are OR-ed in after the ack is removed, so a request for the
      // index being acknowledged this cycle keeps that bit pending.
      if (STICKY) begin
         pending_d = (pending_q & ~ack_mask) | req_in;
      end else begin
         pending_d = req_in & ~ack_mask;
      end
      pend_count_d = popcount16(pending_d);

      // Selection looks at the current register only; requests arriving this
      // cycle become visible one cycle later.
      remaining = pending_q & ~ack_mask;

`ifdef ENCODER_16_ROUND_ROBIN_EN
      // On a handshake the pointer becomes the index being granted; the
      // follow-on selection already uses that updated pointer.
      sel_base = hs ? out_index_q : ptr_q;
      ptr_d    = sel_base;
      sel_idle = sel_rr(pending_q, sel_base);
      sel_rem  = sel_rr(remaining, sel_base);
`else
      sel_idle = sel_fixed(pending_q);
      sel_rem  = sel_fixed(remaining);
`endif

      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_index_d = out_index_q;

      case (state_q)
         IDLE: begin
            out_valid_d = 1'b0;
            if (pending_q != 16'h0000) begin
               out_index_d = sel_idle;
               out_valid_d = 1'b1;
               state_d     = PRESENT;
            end
         end
         PRESENT: begin
            // Without a handshake the presented index is frozen, even if a
            // higher-priority request shows up.
            if (hs) begin
               if (remaining != 16'h0000) begin
                  out_index_d = sel_rem;
                  out_valid_d = 1'b1;
               end else begin
                  // out_index keeps its last value while idle.
                  out_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         pending_q    <= '0;
         pend_count_q <= '0;
         out_valid_q  <= 1'b0;
         out_index_q  <= '0;
`ifdef ENCODER_16_ROUND_ROBIN_EN
         ptr_q        <= 4'hF;
`endif
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         pend_count_q <= pend_count_d;
         out_valid_q  <= out_valid_d;
         out_index_q  <= out_index_d;
`ifdef ENCODER_16_ROUND_ROBIN_EN
         ptr_q        <= ptr_d;
`endif
      end
   end

   assign out_valid  = out_valid_q;
   assign out_index  = out_index_q;
   assign pend_count = pend_count_q;
   assign pending    = pending_q;
   assign state_dbg  = (state_q == PRESENT);

endmodule

// File: tb/tb_encoder_16.sv
// -----------------------------------------------------------------------------
// tb_encoder_16 -- self-checking bench for encoder_16 (default build, fixed
// priority, STICKY=1).
//
// A reference model advances once per rising edge from the same inputs the
// DUT sees and pushes the expected observable status into exp_q. A monitor on
// the falling edge pops one entry per cycle and compares it with the DUT.
// A few directed checks repeat the hand-derived values of key scenarios.
// -----------------------------------------------------------------------------
module tb_encoder_16;

   localparam bit STICKY = 1'b1;
   localparam int W      = 1 + 4 + 5 + 16;   // valid, index, count, pending

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] req;
   logic        out_ready;
   logic        out_valid;
   logic [3:0]  out_index;
   logic [4:0]  pend_count;
   logic [15:0] pending;
   logic        state_dbg;

   always #5 clock = ~clock;

   encoder_16 #(.STICKY(STICKY)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .req        (req),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_index  (out_index),
      .pend_count (pend_count),
      .pending    (pending),
      .state_dbg  (state_dbg)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: a set of outstanding request indices plus the index
   // currently offered. Lowest outstanding index is chosen when choosing.
   // ---------------------------------------------------------------------------
   logic [W-1:0] exp_q[$];
   logic [15:0]  m_pend  = '0;
   logic         m_valid = 1'b0;
   logic [3:0]   m_idx   = '0;

   function automatic logic [3:0] lowest(input logic [15:0] v);
      for (int i = 0; i < 16; i++) begin
         if (v[i]) return 4'(i);
      end
      return 4'd0;
   endfunction

   always @(posedge clock) begin
      logic [15:0] ack;
      logic [15:0] inreq;
      logic [15:0] rem;
      logic [15:0] nxt;
      logic [4:0]  cnt;
      if (reset) begin
         m_pend  = '0;
         m_valid = 1'b0;
         m_idx   = '0;
      end else begin
         ack   = (m_valid && out_ready) ? (16'h0001 << m_idx) : 16'h0000;
         inreq = enable ? req : 16'h0000;
         rem   = m_pend & ~ack;
         nxt   = STICKY ? (rem | inreq) : (inreq & ~ack);
         if (!m_valid) begin
            if (m_pend != 0) begin
               m_idx   = lowest(m_pend);
               m_valid = 1'b1;
            end
         end else if (ack != 0) begin
            if (rem != 0) m_idx = lowest(rem);
            else          m_valid = 1'b0;
         end
         m_pend = nxt;
      end
      cnt = 5'($countones(m_pend));
      exp_q.push_back({m_valid, m_idx, cnt, m_pend});
   end

   // ---------------------------------------------------------------------------
   // Monitor: one expected status per cycle, compared away from the edge.
   // ---------------------------------------------------------------------------
   always @(negedge clock) begin
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("out_valid",  32'(out_valid),  32'(e[25]));
         chk("state_dbg",  32'(state_dbg),  32'(e[25]));
         chk("pend_count", 32'(pend_count), 32'(e[20:16]));
         chk("pending",    32'(pending),    32'(e[15:0]));
         if (out_valid) chk("out_index", 32'(out_index), 32'(e[24:21]));
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks: inputs change 1 time unit after the rising edge.
   // ---------------------------------------------------------------------------
   task automatic drive(input logic en, input logic [15:0] r, input logic rdy);
      @(posedge clock);
      #1;
      reset     = 1'b0;
      enable    = en;
      req       = r;
      out_ready = rdy;
   endtask

   task automatic do_reset(input int n);
      @(posedge clock);
      #1;
      reset = 1'b1;
      req   = '0;
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Directed check of the current cycle's outputs on the falling edge.
   task automatic look(input string name, input logic v, input logic [3:0] idx,
                       input logic [4:0] cnt);
      @(negedge clock);
      chk({name, ".valid"}, 32'(out_valid), 32'(v));
      if (v) chk({name, ".index"}, 32'(out_index), 32'(idx));
      chk({name, ".count"}, 32'(pend_count), 32'(cnt));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin : stim
      logic [15:0] r;
      reset     = 1'b1;
      enable    = 1'b0;
      req       = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clock);

      // Idle: no requests, ready toggling, nothing must appear.
      for (int i = 0; i < 10; i++) drive(1'b1, 16'h0000, 1'(i % 2));
      look("idle", 1'b0, 4'd0, 5'd0);

      // Single pulse on bit 5: presented two cycles after the request cycle.
      drive(1'b1, 16'h0020, 1'b1);
      drive(1'b1, 16'h0000, 1'b1);
      drive(1'b1, 16'h0000, 1'b1);
      look("pulse5", 1'b1, 4'd5, 5'd1);
      drive(1'b1, 16'h0000, 1'b1);
      look("pulse5_done", 1'b0, 4'd0, 5'd0);

      // Three requests drained back to back: 0, 8, 15.
      drive(1'b1, 16'h8101, 1'b1);
      drive(1'b1, 16'h0000, 1'b1);
      drive(1'b1, 16'h0000, 1'b1);
      look("burst0", 1'b1, 4'd0, 5'd3);
      drive(1'b1, 16'h0000, 1'b1);
      look("burst8", 1'b1, 4'd8, 5'd2);
      drive(1'b1, 16'h0000, 1'b1);
      look("burst15", 1'b1, 4'd15, 5'd1);
      drive(1'b1, 16'h0000, 1'b1);
      look("burst_done", 1'b0, 4'd0, 5'd0);

      // Presented index is held while stalled, even when bit 0 arrives.
      drive(1'b1, 16'h0004, 1'b0);
      drive(1'b1, 16'h0000, 1'b0);
      drive(1'b1, 16'h0000, 1'b0);
      drive(1'b1, 16'h0001, 1'b0);
      drive(1'b1, 16'h0000, 1'b0);
      look("stall_hold", 1'b1, 4'd2, 5'd2);
      drive(1'b1, 16'h0000, 1'b1);
      drive(1'b1, 16'h0000, 1'b1);
      look("after_stall", 1'b1, 4'd0, 5'd1);
      repeat (3) drive(1'b1, 16'h0000, 1'b1);

      // Same-cycle set and clear of the presented index.
      drive(1'b1, 16'h0008, 1'b0);
      repeat (3) drive(1'b1, 16'h0000, 1'b0);
      drive(1'b1, 16'h0008, 1'b1);
      repeat (4) drive(1'b1, 16'h0000, 1'b1);

      // Held two-bit request, then reset in the middle of it.
      repeat (8) drive(1'b1, 16'h0003, 1'b1);
      do_reset(1);
      look("mid_reset", 1'b0, 4'd0, 5'd0);
      enable = 1'b1;

      // All sixteen pending at once.
      drive(1'b1, 16'hFFFF, 1'b0);
      drive(1'b1, 16'h0000, 1'b0);
      look("all16", 1'b0, 4'd0, 5'd16);
      repeat (20) drive(1'b1, 16'h0000, 1'b1);

      // enable low: requests ignored with nothing pending.
      repeat (5) drive(1'b0, 16'($urandom), 1'($urandom));
      look("disabled", 1'b0, 4'd0, 5'd0);

      // Drain continues with enable low.
      drive(1'b1, 16'h0C30, 1'b0);
      repeat (8) drive(1'b0, 16'hFFFF, 1'($urandom_range(0, 1)));

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         r = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'h0000;
         drive(1'($urandom_range(0, 7) != 0), r, 1'($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 99) == 0) do_reset(1);
      end
      repeat (30) drive(1'b1, 16'h0000, 1'b1);
      look("final_drain", 1'b0, 4'd0, 5'd0);

      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
